pc_sequencer: RTL and testbench

//  Control block for the fetch-stage PC register (pc). Each cycle it drives
//  pc_write / pc_flush / pc_flush_val / pc_next.
//  It merges boot, branch, jump, hazard-stall, fetch-wait and halt requests

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_redirect_arb.sv | 47 ++++
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage PC sequencer: FSM states, redirect sources
// and the word-alignment helper.
package pc_seq_pkg;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} pcseq_state_e;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_TRAP,
        SRC_MRET,
        SRC_BR,
        SRC_JAL
    } redir_src_e;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select of the PC redirect source and its word-aligned
// target. Trap/mret inputs exist only when PCSEQ_TRAP_EN is defined.
module pc_redirect_arb
    import pc_seq_pkg::*;
(
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jal_valid,
    input  logic [31:0] jal_target,
`ifdef PCSEQ_TRAP_EN
    input  logic        trap_req,
    input  logic [31:0] mtvec,
    input  logic        mret_req,
    input  logic [31:0] mepc,
`endif
    output logic        redir_valid,
    output redir_src_e  redir_src,
    output logic [31:0] redir_target
);

    always_comb begin
        redir_valid  = 1'b0;
        redir_src    = SRC_NONE;
        redir_target = 32'd0;
`ifdef PCSEQ_TRAP_EN
        if (trap_req) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_TRAP;
            redir_target = align_word(mtvec);
        end else if (mret_req) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_MRET;
            redir_target = align_word(mepc);
        end else
`endif
        if (br_taken) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_BR;
            redir_target = align_word(br_target);
        end else if (jal_valid) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_JAL;
            redir_target = align_word(jal_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC control: merges boot, redirect, stall, fetch-wait and halt
// into one PC update. Optional trap support via PCSEQ_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_current,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             load_use_hz,
    input  logic             mem_stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jal_valid,
    input  logic [31:0]      jal_target,
    input  logic             halt_req,
`ifdef PCSEQ_TRAP_EN
    input  logic             trap_req,
    input  logic [31:0]      trap_epc,
    input  logic             mret_req,
    input  logic             mtvec_we,
    input  logic [31:0]      mtvec_wdata,
`endif
    output logic             pc_write,
    output logic             pc_flush,
    output logic [31:0]      pc_flush_val,
    output logic [31:0]      pc_next,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output pcseq_state_e     state_dbg
);

    // Handshake: a fetch of pc_current is in flight while imem_req=1; it
    // completes in any cycle where imem_ready=1. PC changes only on the edge
    // following pc_write=1 or pc_flush=1.

    pcseq_state_e state, state_nx;
    logic         redir_valid;
    redir_src_e   redir_src;
    logic [31:0]  redir_target;
    logic         arb_br, arb_jal;
    logic         trap_take;

    assign state_dbg = state;
    assign pc_next   = pc_current + PC_INC;

    // Jumps decoded in ID are meaningless while a wrong-path fetch drains.
    assign arb_br  = br_taken  && (state == RUN || state == DRAIN);
    assign arb_jal = jal_valid && (state == RUN);

`ifdef PCSEQ_TRAP_EN
    logic [31:0] mtvec, mepc;
    logic        arb_trap, arb_mret;

    assign arb_trap = trap_req && (state == RUN || state == DRAIN);
    assign arb_mret = mret_req && (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtvec <= 32'd0;
            mepc  <= 32'd0;
        end else begin
            if (mtvec_we)  mtvec <= mtvec_wdata;
            if (trap_take) mepc  <= trap_epc;
        end
    end
`endif

    pc_redirect_arb u_arb (
        .br_taken     (arb_br),
        .br_target    (br_target),
        .jal_valid    (arb_jal),
        .jal_target   (jal_target),
`ifdef PCSEQ_TRAP_EN
        .trap_req     (arb_trap),
        .mtvec        (mtvec),
        .mret_req     (arb_mret),
        .mepc         (mepc),
`endif
        .redir_valid  (redir_valid),
        .redir_src    (redir_src),
        .redir_target (redir_target)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        imem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_flush     = 1'b0;
        pc_flush_val = RESET_VEC;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        halted       = 1'b0;
        trap_take    = 1'b0;
        case (state)
            BOOT: begin
                pc_flush = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                if (mem_stall) begin
                    stall_if_id = 1'b1;
                end else if (redir_valid) begin
                    pc_flush     = 1'b1;
                    pc_flush_val = redir_target;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = (redir_src == SRC_BR) || (redir_src == SRC_TRAP);
                    trap_take    = (redir_src == SRC_TRAP);
                    if (!imem_ready) state_nx = DRAIN;
                end
`ifndef PCSEQ_TRAP_EN
                else if (halt_req) begin
                    flush_if_id = 1'b1;
                    state_nx    = HALT;
                end
`endif
                else if (load_use_hz) begin
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (!imem_ready) begin
                    flush_if_id = 1'b1;
                end else begin
                    pc_write = 1'b1;
                end
            end
            DRAIN: begin
                flush_if_id = 1'b1;
                if (!mem_stall && redir_valid) begin
                    pc_flush     = 1'b1;
                    pc_flush_val = redir_target;
                    flush_id_ex  = 1'b1;
                    trap_take    = (redir_src == SRC_TRAP);
                end
                // Once the stale fetch returns nothing is outstanding, even if
                // another redirect lands in the same cycle.
                if (imem_ready) state_nx = RUN;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == RUN && !pc_write && !pc_flush && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifndef PCSEQ_TRAP_EN
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a bench-side PC register closes the loop,
// every expected value is hand-computed.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_current;
    logic         imem_req, imem_ready, load_use_hz, mem_stall;
    logic         br_taken, jal_valid, halt_req;
    logic [31:0]  br_target, jal_target;
    logic         pc_write, pc_flush, stall_if_id, flush_if_id, flush_id_ex, halted;
    logic [31:0]  pc_flush_val, pc_next, stall_cnt;
    pcseq_state_e state_dbg;
`ifdef PCSEQ_TRAP_EN
    logic         trap_req, mret_req, mtvec_we;
    logic [31:0]  trap_epc, mtvec_wdata;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VEC(32'h0), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_current   (pc_current),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .load_use_hz  (load_use_hz),
        .mem_stall    (mem_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jal_valid    (jal_valid),
        .jal_target   (jal_target),
        .halt_req     (halt_req),
`ifdef PCSEQ_TRAP_EN
        .trap_req     (trap_req),
        .trap_epc     (trap_epc),
        .mret_req     (mret_req),
        .mtvec_we     (mtvec_we),
        .mtvec_wdata  (mtvec_wdata),
`endif
        .pc_write     (pc_write),
        .pc_flush     (pc_flush),
        .pc_flush_val (pc_flush_val),
        .pc_next      (pc_next),
        .stall_if_id  (stall_if_id),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .state_dbg    (state_dbg)
    );

    // PC register the sequencer controls.
    initial pc_current = 32'h1234_5678;
    always @(posedge clk) begin
        if (pc_flush)      pc_current <= pc_flush_val;
        else if (pc_write) pc_current <= pc_next;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks sample 2ns later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; imem_ready = 1'b1; load_use_hz = 1'b0; mem_stall = 1'b0;
        br_taken = 1'b0; br_target = 32'h0; jal_valid = 1'b0; jal_target = 32'h0;
        halt_req = 1'b0;
`ifdef PCSEQ_TRAP_EN
        trap_req = 1'b0; trap_epc = 32'h0; mret_req = 1'b0;
        mtvec_we = 1'b0; mtvec_wdata = 32'h0;
`endif
        cycle(); cycle(); #2;
        check("rst_flush", 32'(pc_flush), 32'd1);
        check("rst_val", pc_flush_val, 32'h0);
        check("rst_write", 32'(pc_write), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(BOOT));

        rst = 1'b1; #1;
        check("boot_flush", 32'(pc_flush), 32'd1);
        check("boot_val", pc_flush_val, 32'h0);

        cycle(); #2;
        check("run_state", 32'(state_dbg), 32'(RUN));
        check("pc0", pc_current, 32'h0);
        check("pc0_write", 32'(pc_write), 32'd1);
        check("pc0_next", pc_next, 32'h4);
        check("pc0_req", 32'(imem_req), 32'd1);
        cycle(); #2;
        check("pc4", pc_current, 32'h4);
        cycle();
        check("pc8", pc_current, 32'h8);

        load_use_hz = 1'b1; #2;
        check("lu_write", 32'(pc_write), 32'd0);
        check("lu_id_ex", 32'(flush_id_ex), 32'd1);
        check("lu_stall", 32'(stall_if_id), 32'd1);
        cycle();
        load_use_hz = 1'b0; #2;
        check("lu_pc_hold", pc_current, 32'h8);
        check("lu_cnt", stall_cnt, 32'd1);
        check("lu_resume", 32'(pc_write), 32'd1);

        cycle();
        br_taken = 1'b1; br_target = 32'hDEAD_BEEF; mem_stall = 1'b1; #2;
        check("ms_pc", pc_current, 32'hC);
        check("ms_noflush", 32'(pc_flush), 32'd0);
        check("ms_write", 32'(pc_write), 32'd0);
        check("ms_stall", 32'(stall_if_id), 32'd1);
        cycle();
        mem_stall = 1'b0; #2;
        check("ms_pc_hold", pc_current, 32'hC);
        check("ms_cnt", stall_cnt, 32'd2);
        check("br_flush", 32'(pc_flush), 32'd1);
        check("br_val", pc_flush_val, 32'hDEAD_BEEC);
        check("br_write", 32'(pc_write), 32'd0);
        check("br_if_id", 32'(flush_if_id), 32'd1);
        check("br_id_ex", 32'(flush_id_ex), 32'd1);
        cycle();
        br_taken = 1'b0; #2;
        check("br_pc", pc_current, 32'hDEAD_BEEC);
        check("br_cnt", stall_cnt, 32'd2);

        br_taken = 1'b1; br_target = 32'h100; jal_valid = 1'b1; jal_target = 32'h200; #1;
        check("prio_val", pc_flush_val, 32'h100);
        cycle();
        br_taken = 1'b0; #2;
        check("prio_pc", pc_current, 32'h100);
        check("jal_val", pc_flush_val, 32'h200);
        check("jal_if_id", 32'(flush_if_id), 32'd1);
        check("jal_id_ex", 32'(flush_id_ex), 32'd0);

        cycle();
        jal_valid = 1'b0; br_taken = 1'b1; br_target = 32'h300; imem_ready = 1'b0; #2;
        check("jal_pc", pc_current, 32'h200);
        check("dr_flush", 32'(pc_flush), 32'd1);
        check("dr_val", pc_flush_val, 32'h300);
        cycle();
        br_taken = 1'b0; #2;
        check("dr_state", 32'(state_dbg), 32'(DRAIN));
        check("dr_req", 32'(imem_req), 32'd0);
        check("dr_if_id", 32'(flush_if_id), 32'd1);
        check("dr_write", 32'(pc_write), 32'd0);
        cycle(); #2;
        check("dr_state2", 32'(state_dbg), 32'(DRAIN));
        check("dr_req2", 32'(imem_req), 32'd0);
        check("dr_cnt", stall_cnt, 32'd2);
        cycle();
        imem_ready = 1'b1; #2;
        check("dr_last_if_id", 32'(flush_if_id), 32'd1);
        check("dr_last_write", 32'(pc_write), 32'd0);
        cycle(); #2;
        check("dr_back_run", 32'(state_dbg), 32'(RUN));
        check("dr_pc", pc_current, 32'h300);
        check("dr_next", pc_next, 32'h304);
        check("dr_write_run", 32'(pc_write), 32'd1);
        cycle();
        imem_ready = 1'b0; #2;
        check("bub_pc", pc_current, 32'h304);
        check("bub_write", 32'(pc_write), 32'd0);
        check("bub_if_id", 32'(flush_if_id), 32'd1);
        cycle();
        imem_ready = 1'b1; jal_valid = 1'b1; jal_target = 32'hFFFF_FFFF; #2;
        check("bub_cnt", stall_cnt, 32'd3);
        check("bub_pc_hold", pc_current, 32'h304);
        check("wrap_val", pc_flush_val, 32'hFFFF_FFFC);
        cycle();
        jal_valid = 1'b0; #2;
        check("wrap_pc", pc_current, 32'hFFFF_FFFC);
        check("wrap_next", pc_next, 32'h0);
        check("wrap_write", 32'(pc_write), 32'd1);
        cycle(); #2;
        check("wrap_pc0", pc_current, 32'h0);

`ifdef PCSEQ_TRAP_EN
        mtvec_we = 1'b1; mtvec_wdata = 32'h80; #1;
        cycle();
        mtvec_we = 1'b0; trap_req = 1'b1; trap_epc = 32'h44; #2;
        check("trap_flush", 32'(pc_flush), 32'd1);
        check("trap_val", pc_flush_val, 32'h80);
        check("trap_id_ex", 32'(flush_id_ex), 32'd1);
        cycle();
        trap_req = 1'b0; mret_req = 1'b1; #2;
        check("trap_pc", pc_current, 32'h80);
        check("mret_val", pc_flush_val, 32'h44);
        cycle();
        mret_req = 1'b0; #2;
        check("mret_pc", pc_current, 32'h44);
`else
        halt_req = 1'b1; #1;
        check("halt_if_id", 32'(flush_if_id), 32'd1);
        check("halt_write", 32'(pc_write), 32'd0);
        cycle();
        halt_req = 1'b0; #2;
        check("halt_state", 32'(state_dbg), 32'(HALT));
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cycle(); #2;
            check("halt_hold_write", 32'(pc_write), 32'd0);
            check("halt_hold_req", 32'(imem_req), 32'd0);
        end
        check("halt_pc", pc_current, 32'h0);
        check("halt_cnt", stall_cnt, 32'd4);
`endif

        rst = 1'b0; #1;
        check("rst2_state", 32'(state_dbg), 32'(BOOT));
        check("rst2_flush", 32'(pc_flush), 32'd1);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_cnt", stall_cnt, 32'd0);
        cycle();
        rst = 1'b1; #2;
        check("rst2_boot_flush", 32'(pc_flush), 32'd1);
        cycle(); #2;
        check("rst2_run", 32'(state_dbg), 32'(RUN));
        check("rst2_pc", pc_current, 32'h0);
        check("rst2_write", 32'(pc_write), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
